// File: rtl/ma_job_sequencer.sv
// Job sequencer for a multiply-accumulate array: serially loads N multipliers and
// N multiplicands, strobes the array, waits for its result with timeout recovery.
module ma_job_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int KERNEL_SIZE    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                      Clk,
    input  logic                                      Rst,
    input  logic [DATA_WIDTH-1:0]                     s_data,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplier_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplicand_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]        mStart,
    input  logic [DATA_WIDTH-1:0]                     finalAccumulate,
    input  logic                                      finalReady,
    output logic                                      ma_rst,
    output logic [DATA_WIDTH-1:0]                     m_result,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic                                      busy,
    output logic                                      timeout_err
);

    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        RESULT,
        RECOVER
    } state_t;

    state_t        state, state_next;
    logic [KW-1:0] k, k_next;
    logic [TW-1:0] wait_cnt, wait_cnt_next;
    logic          rec_cnt, rec_cnt_next;
    logic          xfer;
    logic          wr_a, wr_b, capture, set_err;

    assign s_ready = (state == LOAD_A) || (state == LOAD_B);
    assign xfer    = s_valid && s_ready;
    assign mStart  = (state == START) ? '1 : '0;
    assign m_valid = (state == RESULT);
    assign ma_rst  = (state == RECOVER);
    assign busy    = !((state == LOAD_A) && (k == '0));

    always_comb begin
        state_next    = state;
        k_next        = k;
        wait_cnt_next = wait_cnt;
        rec_cnt_next  = rec_cnt;
        wr_a          = 1'b0;
        wr_b          = 1'b0;
        capture       = 1'b0;
        set_err       = 1'b0;
        case (state)
            LOAD_A: begin
                if (xfer) begin
                    wr_a = 1'b1;
                    if (k == K_LAST) begin
                        k_next     = '0;
                        state_next = LOAD_B;
                    end else begin
                        k_next = k + KW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    wr_b = 1'b1;
                    if (k == K_LAST) begin
                        k_next     = '0;
                        state_next = START;
                    end else begin
                        k_next = k + KW'(1);
                    end
                end
            end
            START: begin
                wait_cnt_next = '0;
                state_next    = WAIT;
            end
            WAIT: begin
                // A result on the terminal count still wins over the timeout.
                if (finalReady) begin
                    capture    = 1'b1;
                    state_next = RESULT;
                end else if (wait_cnt == T_LAST) begin
                    set_err      = 1'b1;
                    rec_cnt_next = 1'b0;
                    state_next   = RECOVER;
                end else begin
                    wait_cnt_next = wait_cnt + TW'(1);
                end
            end
            RESULT: begin
                if (m_ready) state_next = LOAD_A;
            end
            RECOVER: begin
                if (rec_cnt) state_next = LOAD_A;
                else rec_cnt_next = 1'b1;
            end
            default: state_next = LOAD_A;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state              <= LOAD_A;
            k                  <= '0;
            wait_cnt           <= '0;
            rec_cnt            <= 1'b0;
            multiplier_input   <= '0;
            multiplicand_input <= '0;
            m_result           <= '0;
            timeout_err        <= 1'b0;
        end else begin
            state    <= state_next;
            k        <= k_next;
            wait_cnt <= wait_cnt_next;
            rec_cnt  <= rec_cnt_next;
            for (int i = 0; i < N; i++) begin
                if (wr_a && (k == KW'(i))) multiplier_input[i*DATA_WIDTH +: DATA_WIDTH]   <= s_data;
                if (wr_b && (k == KW'(i))) multiplicand_input[i*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            end
            if (capture) m_result <= finalAccumulate;
            if (set_err) timeout_err <= 1'b1;
        end
    end

endmodule
